uart_port: RTL and testbench

- Peripheral-side end of the CPU byte-UART interface.
- Accepts a byte plus a transmit-enable strobe from the core's data-memory bus, serialises it as 8N1 on `txd`, and reports busy/idle.
- Deserialises 8N1 frames arriving on `rxd` into a holding register and flags `rx_eff` until the core acknowledges with `rx_read`.
- Sits between the core's memory-mapped UART registers and the board pins.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_port.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_port.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the byte UART.
// Holds the common FSM state enum, frame width and timer-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Width of a counter that has to hold 0..div-1.
    function automatic int timer_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Restartable bit-period timer: counts 0..CLK_DIV-1 and raises tick on the last count.
// Ports: clk, reset, start (reload), half (reload for half a period), tick (period end).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic half,
    output logic tick
);

    localparam int TW = timer_width(CLK_DIV);
    localparam logic [TW-1:0] LAST      = TW'(CLK_DIV - 1);
    // Starting part-way up the count makes the first tick arrive after CLK_DIV/2 cycles.
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV - CLK_DIV / 2);

    logic [TW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= half ? HALF_LOAD : '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/uart_port.sv
// Peripheral side of the CPU byte UART: 8N1 transmitter and receiver.
// Ports: tx_data/tx_en/tx_status/txd for TX, rxd/rx_data/rx_eff/rx_read/rx_overrun/rx_frame_err for RX.
module uart_port
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_status,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_eff,
    input  logic       rx_read,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_t tx_state, tx_state_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic [2:0]  tx_bits, tx_bits_n;
    logic        tx_start, tx_tick;

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
        .clk   (clk),
        .reset (reset),
        .start (tx_start),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_shift <= '0;
            tx_bits  <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_shift <= tx_shift_n;
            tx_bits  <= tx_bits_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_shift_n = tx_shift;
        tx_bits_n  = tx_bits;
        tx_start   = 1'b0;
        unique case (tx_state)
            IDLE: begin
                if (tx_en) begin
                    tx_state_n = START;
                    tx_shift_n = tx_data;
                    tx_start   = 1'b1;
                end
            end
            START: begin
                if (tx_tick) begin
                    tx_state_n = DATA;
                    tx_bits_n  = '0;
                end
            end
            DATA: begin
                if (tx_tick) begin
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bits == LAST_BIT) begin
                        tx_state_n = STOP;
                    end else begin
                        tx_bits_n = tx_bits + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tx_tick) begin
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        unique case (tx_state)
            START:   txd = 1'b0;
            DATA:    txd = tx_shift[0];
            default: txd = 1'b1;
        endcase
    end

    assign tx_status = (tx_state == IDLE);

    // ---------------- receiver ----------------
    logic        rx_meta, rxs;
    uart_state_t rx_state, rx_state_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic [2:0]  rx_bits, rx_bits_n;
    logic        rx_wait, rx_wait_n;
    logic        rx_start, rx_half, rx_tick;
    logic        rx_done, rx_ferr;

    // rxd is asynchronous; idle level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
        .clk   (clk),
        .reset (reset),
        .start (rx_start),
        .half  (rx_half),
        .tick  (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_shift <= '0;
            rx_bits  <= '0;
            rx_wait  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_shift <= rx_shift_n;
            rx_bits  <= rx_bits_n;
            rx_wait  <= rx_wait_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_shift_n = rx_shift;
        rx_bits_n  = rx_bits;
        rx_wait_n  = rx_wait;
        rx_start   = 1'b0;
        rx_half    = 1'b0;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state)
            IDLE: begin
                rx_wait_n = 1'b0;
                if (!rxs) begin
                    rx_state_n = START;
                    rx_start   = 1'b1;
                    rx_half    = 1'b1;
                end
            end
            START: begin
                // Mid-start-bit check rejects short low glitches.
                if (rx_tick) begin
                    if (rxs) begin
                        rx_state_n = IDLE;
                    end else begin
                        rx_state_n = DATA;
                        rx_bits_n  = '0;
                    end
                end
            end
            DATA: begin
                if (rx_tick) begin
                    rx_shift_n = {rxs, rx_shift[7:1]};
                    if (rx_bits == LAST_BIT) begin
                        rx_state_n = STOP;
                    end else begin
                        rx_bits_n = rx_bits + 3'd1;
                    end
                end
            end
            STOP: begin
                if (rx_wait) begin
                    // Bad stop bit: hold off until the line is idle again.
                    if (rxs) begin
                        rx_state_n = IDLE;
                        rx_wait_n  = 1'b0;
                    end
                end else if (rx_tick) begin
                    if (rxs) begin
                        rx_done    = 1'b1;
                        rx_state_n = IDLE;
                    end else begin
                        rx_ferr   = 1'b1;
                        rx_wait_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data      <= '0;
            rx_eff       <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= rx_ferr;
            if (rx_done) begin
                rx_data <= rx_shift;
            end
            // A new byte wins over a same-cycle acknowledge.
            if (rx_done) begin
                rx_eff <= 1'b1;
            end else if (rx_read) begin
                rx_eff <= 1'b0;
            end
            if (rx_done && rx_eff && !rx_read) begin
                rx_overrun <= 1'b1;
            end else if (rx_read) begin
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_port.sv
// Self-checking bench for uart_port with CLK_DIV=16.
// Table-driven RX vectors, hand-written corner sequences and randomized TX/RX traffic.
module tb_uart_port;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    logic       txd;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_eff;
    logic       rx_read;
    logic       rx_overrun;
    logic       rx_frame_err;

    int checks = 0;
    int passed = 0;
    int ferr_cnt = 0;

    uart_port #(.CLK_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_en        (tx_en),
        .tx_status    (tx_status),
        .txd          (txd),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_eff       (rx_eff),
        .rx_read      (rx_read),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles of the frame-error pulse.
    always @(negedge clk) begin
        if (rx_frame_err === 1'b1) ferr_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         do_read;
        logic [7:0] exp_data;
        bit         exp_eff;
        bit         exp_ovr;
        int         exp_ferr;
    } vec_t;

    vec_t vt [6];
    logic [7:0] exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b want %0b", name, act, exp);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h want %02h", name, act, exp);
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    // Drives one 8N1 frame on rxd, LSB first, each bit held DIV cycles.
    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = fr[k];
            repeat (DIV) step();
        end
        rxd = 1'b1;
    endtask

    // Requests a frame and checks every cycle of the expected waveform.
    // poke: issue an extra tx_en mid-frame; abort_at: reset at that cycle.
    task automatic tx_frame(input logic [7:0] b, input bit poke, input int abort_at);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        tx_data = b;
        tx_en   = 1'b1;
        step();
        tx_en   = 1'b0;
        tx_data = 8'h00;
        for (int i = 1; i <= 10 * DIV; i++) begin
            if (abort_at != 0 && i == abort_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk1("abort_txd", txd, 1'b1);
                chk1("abort_tx_status", tx_status, 1'b1);
                return;
            end
            chk1("txd_wave", txd, fr[(i - 1) / DIV]);
            chk1("tx_busy", tx_status, 1'b0);
            if (poke && i == 50) begin
                tx_en   = 1'b1;
                tx_data = 8'h00;
            end else begin
                tx_en = 1'b0;
            end
            step();
        end
        tx_en = 1'b0;
        chk1("tx_idle_after", tx_status, 1'b1);
        chk1("txd_idle_after", txd, 1'b1);
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        step();
        rx_read = 1'b0;
    endtask

    initial begin
        int f0;
        int lat;
        logic [7:0] tb_b, rb_b, hold;

        reset   = 1'b1;
        tx_data = 8'h00;
        tx_en   = 1'b0;
        rxd     = 1'b1;
        rx_read = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        chk1("rst_txd", txd, 1'b1);
        chk1("rst_tx_status", tx_status, 1'b1);
        chk8("rst_rx_data", rx_data, 8'h00);
        chk1("rst_rx_eff", rx_eff, 1'b0);
        chk1("rst_rx_overrun", rx_overrun, 1'b0);
        chk1("rst_rx_frame_err", rx_frame_err, 1'b0);

        // Basic transmit of 0x55.
        tx_frame(8'h55, 1'b0, 0);
        repeat (2) step();

        // Receive latency for 0xA3, measured from the falling edge.
        lat = -1;
        fork
            send_rx(8'hA3, 1'b1);
            begin
                for (int k = 1; k <= 200 && lat < 0; k++) begin
                    step();
                    if (rx_eff === 1'b1) lat = k;
                end
            end
        join
        checks++;
        if (lat >= 148 && lat <= 160) passed++;
        else $display("FAIL rx_latency: got %0d want 148..160", lat);
        chk8("lat_rx_data", rx_data, 8'hA3);
        pulse_read();
        chk1("lat_read_clears", rx_eff, 1'b0);
        repeat (4) step();

        // Table-driven receive vectors.
        vt[0] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 0};
        vt[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 0};
        vt[2] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 0};
        vt[3] = '{8'h3C, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1};
        vt[4] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 0};
        hold  = 8'($urandom_range(0, 255));
        vt[5] = '{hold, 1'b1, 1'b1, hold, 1'b1, 1'b0, 0};

        for (int v = 0; v < 6; v++) begin
            f0 = ferr_cnt;
            send_rx(vt[v].data, vt[v].stop_ok);
            repeat (4) step();
            chk8($sformatf("vec%0d_data", v), rx_data, vt[v].exp_data);
            chk1($sformatf("vec%0d_eff", v), rx_eff, vt[v].exp_eff);
            chk1($sformatf("vec%0d_ovr", v), rx_overrun, vt[v].exp_ovr);
            chkn($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vt[v].exp_ferr);
            if (vt[v].do_read) begin
                pulse_read();
                chk1($sformatf("vec%0d_eff_clr", v), rx_eff, 1'b0);
                chk1($sformatf("vec%0d_ovr_clr", v), rx_overrun, 1'b0);
            end
            repeat (4) step();
        end

        // Acknowledge with nothing pending leaves the byte alone.
        hold = rx_data;
        pulse_read();
        chk1("idle_read_eff", rx_eff, 1'b0);
        chk8("idle_read_data", rx_data, hold);

        // Short low glitch is rejected, then a real frame arrives.
        f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (5) step();
        rxd = 1'b1;
        repeat (20) step();
        chk1("glitch_eff", rx_eff, 1'b0);
        chkn("glitch_ferr", ferr_cnt - f0, 0);
        send_rx(8'h7E, 1'b1);
        repeat (4) step();
        chk1("post_glitch_eff", rx_eff, 1'b1);
        chk8("post_glitch_data", rx_data, 8'h7E);
        pulse_read();
        repeat (2) step();

        // Reset while transmitting data bit 4, then a full 0xFF
        // with an ignored second request in the middle.
        tx_frame(8'h96, 1'b0, 1 + 5 * DIV + 7);
        repeat (2) step();
        tx_frame(8'hFF, 1'b1, 0);
        repeat (2) step();

        // Random concurrent traffic against a queue model.
        for (int r = 0; r < 5; r++) begin
            tb_b = 8'($urandom_range(0, 255));
            rb_b = 8'($urandom_range(0, 255));
            exp_q.push_back(rb_b);
            fork
                tx_frame(tb_b, 1'b0, 0);
                send_rx(rb_b, 1'b1);
            join
            repeat (4) step();
            hold = exp_q.pop_front();
            chk8($sformatf("rand%0d_data", r), rx_data, hold);
            chk1($sformatf("rand%0d_eff", r), rx_eff, 1'b1);
            chk1($sformatf("rand%0d_ovr", r), rx_overrun, 1'b0);
            pulse_read();
            chk1($sformatf("rand%0d_eff_clr", r), rx_eff, 1'b0);
            repeat (3) step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
